// File: rtl/umi_switch_pkg.sv
// Shared definitions for the UMI switch front end.
// Holds the default port-id field position/width inside dstaddr and the
// id -> one-hot port decode used at enqueue time.
package umi_switch_pkg;

    localparam int unsigned UMI_IDLSB = 40;
    localparam int unsigned UMI_IDW   = 3;
    localparam int unsigned UMI_MAXP  = 32;

    // One-hot port vector for a port id; ids >= m fall back to defport.
    // Callers keep the low m bits.
    function automatic logic [UMI_MAXP-1:0] onehot_port(input int unsigned id,
                                                        input int unsigned m,
                                                        input int unsigned defport);
        logic [UMI_MAXP-1:0] vec;
        vec = (id < m) ? (UMI_MAXP'(1) << id) : (UMI_MAXP'(1) << defport);
        return vec;
    endfunction

endpackage

// File: rtl/umi_ingress_fifo2.sv
// Two-entry registered FIFO with the head entry exposed as a register.
// Ports: clk, nreset (async active-low), push/din, pop, full, empty, head.
// Pushes while full and pops while empty are ignored.
module umi_ingress_fifo2 #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push,
    input  logic [PW-1:0] din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] head
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head      = head_q;
    assign push_ok_c = push & ~full;
    assign pop_ok_c  = pop & ~empty;

    // Next-state: new data lands in head when it would otherwise be empty,
    // so a push concurrent with popping the last entry has no bubble.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_ok_c, pop_ok_c})
            2'b10: begin
                if (count_q == 2'd0) head_d = din;
                else                 tail_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = din;
                end else begin
                    head_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/umi_switch_ingress.sv
// Per-input front end of the UMI switch: decodes dstaddr into a one-hot
// output-port request, buffers up to two transactions and holds the head
// stable until the switch accepts it.
// Ports: clk, nreset, err_clear, umi_in_* (upstream valid/ready stream),
// umi_out_* (request + head payload, ready from switch), route_err.
// Optional: define UMI_SWITCH_INGRESS_ERRCNT_EN to add err_count[15:0],
// a saturating count of out-of-range port ids.
module umi_switch_ingress
    import umi_switch_pkg::*;
#(
    parameter int unsigned DW      = 256,
    parameter int unsigned CW      = 32,
    parameter int unsigned AW      = 64,
    parameter int unsigned M       = 6,
    parameter int unsigned IDLSB   = UMI_IDLSB,
    parameter int unsigned IDW     = UMI_IDW,
    parameter int unsigned DEFPORT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          err_clear,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic [M-1:0]  umi_out_request,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready,
    output logic          route_err
`ifdef UMI_SWITCH_INGRESS_ERRCNT_EN
    ,
    output logic [15:0]   err_count
`endif
);

    localparam int unsigned PW = M + CW + 2*AW + DW;

    logic [IDW-1:0] id_c;
    logic [M-1:0]   onehot_c;
    logic           oor_c;
    logic           accept_c;
    logic           pop_c;
    logic           full_c;
    logic           empty_c;
    logic [PW-1:0]  head_c;
    logic [M-1:0]   head_req_c;
    logic           route_err_q, route_err_d;

    // Port decode happens once at enqueue; the vector travels with the entry.
    assign id_c     = umi_in_dstaddr[IDLSB +: IDW];
    assign oor_c    = (32'(id_c) >= M);
    assign onehot_c = M'(onehot_port(32'(id_c), M, DEFPORT));

    assign umi_in_ready = ~full_c;
    assign accept_c     = umi_in_valid & umi_in_ready;
    assign pop_c        = (|umi_out_request) & umi_out_ready;

    umi_ingress_fifo2 #(.PW(PW)) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (accept_c),
        .din    ({onehot_c, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data}),
        .pop    (pop_c),
        .full   (full_c),
        .empty  (empty_c),
        .head   (head_c)
    );

    assign {head_req_c, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = head_c;
    assign umi_out_request = empty_c ? '0 : head_req_c;

    // Sticky routing error: a new set wins over a same-cycle clear.
    always_comb begin
        route_err_d = route_err_q;
        if (accept_c && oor_c) route_err_d = 1'b1;
        else if (err_clear)    route_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) route_err_q <= 1'b0;
        else         route_err_q <= route_err_d;
    end

    assign route_err = route_err_q;

`ifdef UMI_SWITCH_INGRESS_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating error counter; increment wins over clear.
    always_comb begin
        err_count_d = err_count_q;
        if (accept_c && oor_c) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end else if (err_clear) begin
            err_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) err_count_q <= 16'd0;
        else         err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule
